// File: rtl/debug_uart_tx_buffered_pkg.sv
// Shared definitions for the buffered debug UART transmitter:
// serialiser state encoding, frame payload width and peripheral select codes.
package debug_uart_tx_buffered_pkg;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

    localparam int PAYLOAD_BITS = 8;

    // Peripheral select codes: byte write port and its status register
    localparam logic [3:0] PERI_DEBUG_UART        = 4'h6;
    localparam logic [3:0] PERI_DEBUG_UART_STATUS = 4'h7;

endpackage

// File: rtl/debug_uart_tx_buffered_fifo.sv
// Synchronous FIFO with exact occupancy count; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module debug_uart_tx_buffered_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         data_in,
    output logic [WIDTH-1:0]         data_out,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign data_out = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/debug_uart_tx_buffered.sv
// Buffered 8N1 debug UART transmitter: CPU byte writes queue in a FIFO and are
// serialised back-to-back at baud_divider clocks per bit.
//
//   state      | meaning
//   UART_IDLE  | line high, waiting for a queued byte
//   UART_START | start bit (low) for one bit period
//   UART_DATA  | eight data bits, LSB first
//   UART_STOP  | stop bit (high); pops the next byte directly if one is queued
module debug_uart_tx_buffered
    import debug_uart_tx_buffered_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int COUNT_REG_LEN = 13
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [7:0]                 wr_data,
    input  logic [COUNT_REG_LEN-1:0]   baud_divider,
    input  logic                       clr_overflow,
    output logic                       uart_txd,
    output logic                       tx_busy,
    output logic                       fifo_full,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow
);

    localparam logic [2:0] LAST_BIT = 3'(PAYLOAD_BITS - 1);

    uart_state_t               state;
    uart_state_t               state_next;
    logic [COUNT_REG_LEN-1:0]  div_cnt;
    logic [COUNT_REG_LEN-1:0]  div_cnt_next;
    logic [COUNT_REG_LEN-1:0]  div_latched;
    logic [COUNT_REG_LEN-1:0]  div_latched_next;
    logic [COUNT_REG_LEN-1:0]  div_eff;
    logic [7:0]                shifter;
    logic [7:0]                shifter_next;
    logic [2:0]                bit_idx;
    logic [2:0]                bit_idx_next;
    logic                      tc;
    logic                      pop;
    logic                      txd;
    logic [7:0]                fifo_data;
    logic                      fifo_empty;
    logic                      drop;

    debug_uart_tx_buffered_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (wr_en),
        .pop      (pop),
        .data_in  (wr_data),
        .data_out (fifo_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign div_eff  = (baud_divider == '0) ? COUNT_REG_LEN'(1) : baud_divider;
    assign tc       = (div_cnt == '0);
    assign drop     = wr_en & fifo_full & ~pop;
    assign uart_txd = txd;
    assign tx_busy  = (fifo_count != '0) | (state != UART_IDLE);

    always_comb begin
        state_next       = state;
        div_cnt_next     = div_cnt;
        div_latched_next = div_latched;
        shifter_next     = shifter;
        bit_idx_next     = bit_idx;
        pop              = 1'b0;
        txd              = 1'b1;

        case (state)
            UART_IDLE: begin
                if (!fifo_empty) begin
                    pop              = 1'b1;
                    shifter_next     = fifo_data;
                    div_latched_next = div_eff;
                    div_cnt_next     = div_eff - 1'b1;
                    state_next       = UART_START;
                end
            end
            UART_START: begin
                txd = 1'b0;
                if (tc) begin
                    div_cnt_next = div_latched - 1'b1;
                    bit_idx_next = '0;
                    state_next   = UART_DATA;
                end else begin
                    div_cnt_next = div_cnt - 1'b1;
                end
            end
            UART_DATA: begin
                txd = shifter[0];
                if (tc) begin
                    shifter_next = {1'b0, shifter[7:1]};
                    div_cnt_next = div_latched - 1'b1;
                    if (bit_idx == LAST_BIT) begin
                        state_next = UART_STOP;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end else begin
                    div_cnt_next = div_cnt - 1'b1;
                end
            end
            UART_STOP: begin
                if (tc) begin
                    // Chain straight into the next start bit to avoid an idle gap
                    if (!fifo_empty) begin
                        pop              = 1'b1;
                        shifter_next     = fifo_data;
                        div_latched_next = div_eff;
                        div_cnt_next     = div_eff - 1'b1;
                        state_next       = UART_START;
                    end else begin
                        state_next = UART_IDLE;
                    end
                end else begin
                    div_cnt_next = div_cnt - 1'b1;
                end
            end
            default: state_next = UART_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= UART_IDLE;
            div_cnt     <= '0;
            div_latched <= COUNT_REG_LEN'(1);
            shifter     <= '0;
            bit_idx     <= '0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_next;
            div_cnt     <= div_cnt_next;
            div_latched <= div_latched_next;
            shifter     <= shifter_next;
            bit_idx     <= bit_idx_next;
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_debug_uart_tx_buffered.sv
// Scoreboard bench for debug_uart_tx_buffered: a frame-level reference model
// predicts queue contents and frame start times; a monitor decodes the line.
module tb_debug_uart_tx_buffered;

    localparam int DEPTH = 8;
    localparam int CRL   = 13;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_en;
    logic [7:0]      wr_data;
    logic [CRL-1:0]  baud_divider;
    logic            clr_overflow;
    logic            uart_txd;
    logic            tx_busy;
    logic            fifo_full;
    logic [3:0]      fifo_count;
    logic            overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    debug_uart_tx_buffered #(.DEPTH(DEPTH), .COUNT_REG_LEN(CRL)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .baud_divider (baud_divider),
        .clr_overflow (clr_overflow),
        .uart_txd     (uart_txd),
        .tx_busy      (tx_busy),
        .fifo_full    (fifo_full),
        .fifo_count   (fifo_count),
        .overflow     (overflow)
    );

    typedef struct {
        logic [7:0] data;
        int         d;
        int         start;
    } frame_t;

    frame_t     exp_q[$];
    logic [7:0] m_fifo[$];
    int         m_left = 0;
    bit         m_ovf  = 0;
    bit         m_pop;
    bit         m_push;
    frame_t     m_f;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, req, cyc);
        end
    endtask

    // Reference model: a frame occupies 10*D clocks; the next byte is taken
    // when the line is idle or in the last clock of the current frame.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_fifo.delete();
            exp_q.delete();
            m_left = 0;
            m_ovf  = 0;
        end else begin
            m_pop  = (m_fifo.size() != 0) && (m_left <= 1);
            m_push = wr_en && ((m_fifo.size() < DEPTH) || m_pop);
            if (m_pop) begin
                m_f.data  = m_fifo.pop_front();
                m_f.d     = (baud_divider == 0) ? 1 : int'(baud_divider);
                m_f.start = cyc + 1;
                exp_q.push_back(m_f);
                m_left = 10 * m_f.d;
            end else if (m_left > 0) begin
                m_left--;
            end
            if (m_push) m_fifo.push_back(wr_data);
            if (wr_en && !m_push) m_ovf = 1;
            else if (clr_overflow) m_ovf = 0;
            cyc++;
        end
    end

    // Monitor: status outputs every cycle, serial line decoded per frame
    bit     mon_active = 0;
    int     mon_t;
    int     mon_b;
    int     exp_bit;
    frame_t mon_f;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            mon_active = 0;
        end else begin
            check("fifo_count", int'(fifo_count), m_fifo.size());
            check("fifo_full", int'(fifo_full), int'(m_fifo.size() == DEPTH));
            check("overflow", int'(overflow), int'(m_ovf));
            check("tx_busy", int'(tx_busy), int'((m_fifo.size() != 0) || (m_left != 0)));
            if (!mon_active && uart_txd == 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_start", 0, 1);
                end else begin
                    mon_f = exp_q.pop_front();
                    check("frame_start", cyc, mon_f.start);
                    mon_active = 1;
                    mon_t      = 0;
                end
            end
            if (mon_active) begin
                mon_b = mon_t / mon_f.d;
                if (mon_b == 0) exp_bit = 0;
                else if (mon_b == 9) exp_bit = 1;
                else exp_bit = int'(mon_f.data[mon_b-1]);
                check("txd_bit", int'(uart_txd), exp_bit);
                mon_t++;
                if (mon_t == 10 * mon_f.d) mon_active = 0;
            end
        end
    end

    task automatic write_burst(input int n, input logic [7:0] first);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = first + 8'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (!tx_busy && m_left == 0 && m_fifo.size() == 0 && !mon_active) break;
            @(negedge clk);
        end
        if (i == budget) check("drain_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    int n;

    initial begin
        rst          = 1'b1;
        wr_en        = 1'b0;
        wr_data      = '0;
        clr_overflow = 1'b0;
        baud_divider = CRL'(25);
        repeat (3) @(negedge clk);
        check("rst_txd", int'(uart_txd), 1);
        check("rst_busy", int'(tx_busy), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_full", int'(fifo_full), 0);
        check("rst_overflow", int'(overflow), 0);
        rst = 1'b0;
        @(negedge clk);

        // Single byte at D=25: busy must fall 252 cycles after the write
        n = cyc;
        write_burst(1, 8'h55);
        for (int i = 0; i < 400; i++) begin
            if (!tx_busy) break;
            @(negedge clk);
        end
        check("t1_busy_fall", cyc, n + 252);

        // Burst of DEPTH bytes: no drops
        baud_divider = CRL'(4);
        write_burst(8, 8'h01);
        wait_idle(1000);
        check("t2_overflow", int'(overflow), 0);

        // Ten writes: one slot freed by the first pop, the tenth is dropped
        write_burst(10, 8'h20);
        check("t3_overflow_set", int'(overflow), 1);
        check("t3_count_full", int'(fifo_count), DEPTH);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        check("t3_overflow_clr", int'(overflow), 0);

        // Write into a full FIFO in the same cycle as the stop-to-start pop
        begin
            int i;
            for (i = 0; i < 200; i++) begin
                if (m_left == 1 && m_fifo.size() == DEPTH) break;
                @(negedge clk);
            end
            if (i == 200) check("t4_wait_timeout", 0, 1);
        end
        wr_en   = 1'b1;
        wr_data = 8'hC3;
        @(negedge clk);
        wr_en = 1'b0;
        check("t4_count_stays", int'(fifo_count), DEPTH);
        check("t4_no_overflow", int'(overflow), 0);
        wait_idle(2000);

        // Reset during data bit 3 of a frame with more bytes queued
        write_burst(3, 8'hF0);
        repeat (16) @(negedge clk);
        check("t5_pre_reset_txd", int'(uart_txd), 0);
        #2 rst = 1'b1;
        #1;
        check("t5_reset_txd", int'(uart_txd), 1);
        check("t5_reset_count", int'(fifo_count), 0);
        check("t5_reset_busy", int'(tx_busy), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        write_burst(1, 8'hA5);
        wait_idle(200);

        // Divider 0 acts as 1; divider change mid-frame applies to the next frame
        baud_divider = '0;
        write_burst(1, 8'h3C);
        wait_idle(100);
        baud_divider = CRL'(4);
        write_burst(2, 8'h96);
        repeat (10) @(negedge clk);
        baud_divider = CRL'(8);
        wait_idle(500);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            wr_en        = ($urandom_range(0, 2) == 0);
            wr_data      = 8'($urandom);
            clr_overflow = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) baud_divider = CRL'($urandom_range(0, 5));
            @(negedge clk);
        end
        wr_en        = 1'b0;
        clr_overflow = 1'b0;
        wait_idle(3000);
        check("end_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
